mc_control_fsm: RTL

//  Multi-cycle sequencer for the RV32I datapath: replaces the single-cycle decoder with a Moore FSM.

---
 rtl/mc_control_fsm_if.sv | 12 +
 rtl/mc_control_fsm.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm_if.sv
// Memory handshake between the multi-cycle controller (master) and the shared
// instruction/data memory (slave).
interface mc_control_fsm_if;
  logic mem_req;
  logic mem_ready;
  logic i_or_d;
  logic mem_read;
  logic mem_write;

  modport master (output mem_req, i_or_d, mem_read, mem_write, input mem_ready);
  modport slave  (input mem_req, i_or_d, mem_read, mem_write, output mem_ready);
endinterface

// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I sequencer: Moore FSM driving memory, ALU-mux and write enables.
// Optional MC_PERF_CNT_EN adds free-running cycle and retired-instruction counters.
//
// state | meaning
// IF    | fetch; wait for mem_ready, then latch IR and advance PC
// ID    | decode; compute branch target, resolve ECALL
// EX    | execute per opcode class
// MEM   | data access for LOAD/STORE; wait for mem_ready
// WB    | register write-back
// HALT  | terminal until reset
module mc_control_fsm #(
  parameter int HALT_CODE = 10,
  parameter int WAIT_MAX  = 255,
  parameter int WDT_W     = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  mc_control_fsm_if.master        mem,
  input  logic [6:0]              opcode,
  input  logic                    bcond,
  input  logic [31:0]             x17_val,
  output logic                    ir_write,
  output logic                    reg_write,
  output logic                    mem_to_reg,
  output logic                    pc_to_reg,
  output logic                    alu_src_a,
  output logic [1:0]              alu_src_b,
  output logic [1:0]              alu_ctl_sel,
  output logic                    pc_write,
  output logic                    pc_write_cond,
  output logic                    pc_source,
  output logic                    is_halted,
  output logic                    mem_error
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0]             cycle_cnt,
  output logic [31:0]             retire_cnt
`endif
);

  localparam logic [2:0] S_IF   = 3'd0;
  localparam logic [2:0] S_ID   = 3'd1;
  localparam logic [2:0] S_EX   = 3'd2;
  localparam logic [2:0] S_MEM  = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;
  localparam logic [2:0] S_HALT = 3'd5;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [WDT_W-1:0] wdt_cnt;
  logic             waiting;
  logic             wdt_fire;
  logic             unused_bcond;

  // bcond is qualified in the datapath; the controller only raises pc_write_cond.
  assign unused_bcond = bcond;

  always_comb begin
    mem.mem_req   = 1'b0;
    mem.i_or_d    = 1'b0;
    mem.mem_read  = 1'b0;
    mem.mem_write = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    pc_to_reg     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    alu_ctl_sel   = 2'd0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 1'b0;
    state_nxt     = state;
    case (state)
      S_IF: begin
        mem.mem_req  = 1'b1;
        mem.mem_read = 1'b1;
        alu_src_b    = 2'd1;
        if (mem.mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          state_nxt = S_ID;
        end
      end
      S_ID: begin
        alu_src_b = 2'd2;
        case (opcode)
          OP_ECALL: state_nxt = (x17_val == 32'(HALT_CODE)) ? S_HALT : S_IF;
          OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR: state_nxt = S_EX;
          default:  state_nxt = S_IF;
        endcase
      end
      S_EX: begin
        state_nxt = S_WB;
        case (opcode)
          OP_R: begin
            alu_src_a   = 1'b1;
            alu_ctl_sel = 2'd1;
          end
          OP_I: begin
            alu_src_a   = 1'b1;
            alu_src_b   = 2'd2;
            alu_ctl_sel = 2'd1;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
            state_nxt = S_MEM;
          end
          OP_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_ctl_sel   = 2'd2;
            pc_write_cond = 1'b1;
            pc_source     = 1'b1;
            state_nxt     = S_IF;
          end
          OP_JAL:  alu_src_b = 2'd2;
          OP_JALR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
          end
          default: state_nxt = S_IF;
        endcase
      end
      S_MEM: begin
        mem.mem_req   = 1'b1;
        mem.i_or_d    = 1'b1;
        mem.mem_read  = (opcode == OP_LOAD);
        mem.mem_write = (opcode == OP_STORE);
        if (mem.mem_ready) state_nxt = (opcode == OP_LOAD) ? S_WB : S_IF;
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (opcode == OP_LOAD);
        if ((opcode == OP_JAL) || (opcode == OP_JALR)) begin
          pc_to_reg = 1'b1;
          pc_write  = 1'b1;
          pc_source = 1'b1;
        end
        state_nxt = S_IF;
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IF;
    endcase

    waiting  = ((state == S_IF) || (state == S_MEM)) && !mem.mem_ready;
    wdt_fire = (WAIT_MAX != 0) && waiting && (wdt_cnt == WDT_W'(WAIT_MAX - 1));
    if (wdt_fire) state_nxt = S_HALT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IF;
      wdt_cnt   <= '0;
      is_halted <= 1'b0;
      mem_error <= 1'b0;
    end else begin
      state <= state_nxt;
      // Saturating wait counter; any completed access or state change restarts it.
      if (waiting) wdt_cnt <= (wdt_cnt == '1) ? wdt_cnt : wdt_cnt + 1'b1;
      else         wdt_cnt <= '0;
      if (state_nxt == S_HALT) is_halted <= 1'b1;
      if (wdt_fire)            mem_error <= 1'b1;
    end
  end

`ifdef MC_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt  <= '0;
      retire_cnt <= '0;
    end else if (state != S_HALT) begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if ((state_nxt == S_IF) && (state != S_IF)) retire_cnt <= retire_cnt + 32'd1;
    end
  end
`endif

endmodule
